matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Sequences one full square matrix multiply C = A x B over the shared MAC datapath.
- Generates read addresses for MemA/MemB, MAC load/accumulate strobes and MemC write strobes from a single start command and a matrix size.
- Sits between the top-level command FSM and the MAC/memory datapath, replacing the hand-stepped MAC states.
- Fully pipelined: one inner-product term issued per clock, no stalls between output elements.

Parameters:
- ADDR_W, 16, width of all memory address outputs.
- MAX_N, 16, largest accepted matrix dimension.
- ADDR_OFS, 1, address offset added to every element address (address 0 of each memory holds the matrix length).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled request; accepted only in IDLE.
- size  input  8  matrix dimension N, latched on start acceptance.
- busy  output  1  high from the first issue cycle through the last C write.
- done  output  1  one-cycle pulse when the multiply completes (including N=0).
- err  output  1  one-cycle pulse when start is rejected because size > MAX_N.
- a_addr  output  ADDR_W  MemA read address = i*N + j + ADDR_OFS.
- b_addr  output  ADDR_W  MemB read address = j*N + k + ADDR_OFS.
- rd_en  output  1  read strobe for MemA/MemB (synchronous read, data valid next cycle).
- mac_en  output  1  MAC multiplies current A/B data this cycle.
- mac_load  output  1  with mac_en: load the product, discarding the accumulator (first term, j=0).
- c_we  output  1  MemC write strobe; data is the MAC accumulator output.
- c_addr  output  ADDR_W  MemC write address = i*N + k + ADDR_OFS.

Behaviour:
- Reset (async, any time): state=IDLE, all outputs 0, index counters i/j/k = 0, pipeline valids cleared. No c_we is issued for a partly computed element.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - size=0: go to DONE; no rd_en, mac_en or c_we.
  - size>MAX_N: pulse err next cycle and stay in IDLE.
  - Otherwise: latch N, clear i/j/k, go to RUN.
- RUN issue order: j innermost, then k, then i (row-major C). One term per cycle with rd_en=1.
  - j wraps at N-1 to 0 and increments k.
  - k wraps at N-1 to 0 and increments i.
  - After issuing (i,j,k) = (N-1, N-1, N-1), go to DRAIN.
- Pipeline, taking cycle 0 as the start-accept cycle:
  - Stage 0 (issue): rd_en, a_addr, b_addr, with first = (j==0) and last = (j==N-1) tags.
  - Stage 1 (one cycle later): mac_en=1; mac_load = first tag.
  - Stage 2 (two cycles after issue): c_we = last tag, with c_addr carried from issue.
  - The next element's mac_load edge coincides with the previous element's c_we cycle. The accumulator holds the final value during that cycle, so no bubble is needed.
- Timing:
  - Issue cycles are 1..N^3.
  - mac_en is high on cycles 2..N^3+1.
  - Exactly N^2 c_we pulses occur; the last one is on cycle N^3+2.
  - busy is high on cycles 1..N^3+2.
  - DONE on cycle N^3+3: done=1, busy=0; back to IDLE the next cycle.
- DRAIN lasts exactly 2 cycles. start is ignored in RUN, DRAIN and DONE (no queuing).
- Address arithmetic:
  - Computed with incremental row-base registers (add N), not multipliers.
  - Results are truncated to ADDR_W. MAX_N must satisfy MAX_N^2 + ADDR_OFS < 2^ADDR_W.
- size changing after acceptance has no effect.

Test Plan:
- N=1, A=[3], B=[5]:
  - mac_en+mac_load on cycle 2; c_we on cycle 3 with c_addr=1; done on cycle 4.
  - MemC[1]=15; exactly one write.
- N=2, A=[1 2;3 4], B=[5 6;7 8]:
  - MemC[1..4] = 19, 22, 43, 50; 4 c_we pulses on cycles 4, 6, 8, 10.
  - done on cycle 11; busy high on cycles 1..10.
- N=3, identity times arbitrary B:
  - Check the a_addr/b_addr sequence for the first 6 issues: a = 1,2,3,1,2,3; b = 1,4,7,2,5,8.
  - MemC equals B; 9 writes; done on cycle 30.
- size=0 -> done pulse on cycle 1, no rd_en/mac_en/c_we. size=17 with MAX_N=16 -> err pulse, busy stays 0, no done.
- Start held high throughout an N=2 run -> only one multiply executes; a new run is accepted only on the IDLE cycle after done.
- Assert rst on cycle 5 of an N=3 run:
  - All outputs 0 immediately (asynchronously); no further c_we or done.
  - A fresh start then completes normally with correct MemC contents.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Address/strobe sequencer for one square C = A x B over a shared MAC datapath.
// Issues one inner-product term per clock; MAC and MemC strobes trail issue by 1 and 2 cycles.
module matmul_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int MAX_N    = 16,
  parameter int ADDR_OFS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              rd_en,
  output logic              mac_en,
  output logic              mac_load,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0]        MAX_N_8 = 8'(MAX_N);
  localparam logic [ADDR_W-1:0] OFS     = ADDR_W'(ADDR_OFS);
  localparam logic [ADDR_W-1:0] OFS_P1  = ADDR_W'(ADDR_OFS + 1);

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d, c_cur_q, c_cur_d;
  logic              drain_q, drain_d, err_q, err_d;
  logic              s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [ADDR_W-1:0] s1_caddr_q, s1_caddr_d, s2_caddr_q, s2_caddr_d;
  logic              s2_we_q, s2_we_d;

  logic              issue, accept, size_bad, j_last, k_last, i_last;
  logic [7:0]        n_m1;
  logic [ADDR_W-1:0] n_ext;

  assign issue    = (state_q == S_RUN);
  assign size_bad = (size > MAX_N_8);
  assign accept   = (state_q == S_IDLE) && start && (size != 8'd0) && !size_bad;
  assign n_m1     = n_q - 8'd1;
  assign j_last   = (j_q == n_m1);
  assign k_last   = (k_q == n_m1);
  assign i_last   = (i_q == n_m1);
  assign n_ext    = ADDR_W'(n_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_row_q    <= '0;
      c_cur_q    <= '0;
      drain_q    <= 1'b0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_caddr_q <= '0;
      s2_we_q    <= 1'b0;
      s2_caddr_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_row_q    <= a_row_d;
      c_cur_q    <= c_cur_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_caddr_q <= s1_caddr_d;
      s2_we_q    <= s2_we_d;
      s2_caddr_q <= s2_caddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && size == 8'd0) state_d = S_DONE;
               else if (accept)           state_d = S_RUN;
      S_RUN:   if (i_last && j_last && k_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row bases advance by N instead of multiplying; c_cur is row-major so it just counts.
  always_comb begin
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_row_d    = a_row_q;
    c_cur_d    = c_cur_q;
    drain_d    = (state_q == S_DRAIN) ? ~drain_q : 1'b0;
    err_d      = (state_q == S_IDLE) && start && size_bad;
    s1_valid_d = issue;
    s1_first_d = issue && (j_q == 8'd0);
    s1_last_d  = issue && j_last;
    s1_caddr_d = c_cur_q;
    s2_we_d    = s1_valid_q && s1_last_q;
    s2_caddr_d = s1_caddr_q;
    if (accept) begin
      n_d      = size;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      a_addr_d = OFS;
      b_addr_d = OFS;
      a_row_d  = OFS;
      c_cur_d  = OFS;
    end else if (issue) begin
      if (!j_last) begin
        j_d      = j_q + 8'd1;
        a_addr_d = a_addr_q + ADDR_W'(1);
        b_addr_d = b_addr_q + n_ext;
      end else begin
        j_d     = '0;
        c_cur_d = c_cur_q + ADDR_W'(1);
        if (!k_last) begin
          k_d      = k_q + 8'd1;
          a_addr_d = a_row_q;
          b_addr_d = ADDR_W'(k_q) + OFS_P1;
        end else begin
          k_d      = '0;
          i_d      = i_q + 8'd1;
          a_row_d  = a_row_q + n_ext;
          a_addr_d = a_row_q + n_ext;
          b_addr_d = OFS;
        end
      end
    end
  end

  always_comb begin
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
    err      = err_q;
    rd_en    = issue;
    a_addr   = issue ? a_addr_q : '0;
    b_addr   = issue ? b_addr_q : '0;
    mac_en   = s1_valid_q;
    mac_load = s1_valid_q && s1_first_q;
    c_we     = s2_we_q;
    c_addr   = s2_we_q ? s2_caddr_q : '0;
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench: sequencer driving a behavioural MemA/MemB/MAC/MemC model, with cycle-exact checks.
module tb_matmul_sequencer;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  size;
  logic        busy, done, err, rd_en, mac_en, mac_load, c_we;
  logic [15:0] a_addr, b_addr, c_addr;

  int total = 0;
  int bad = 0;

  matmul_sequencer #(.ADDR_W(16), .MAX_N(16), .ADDR_OFS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .busy(busy), .done(done), .err(err),
    .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en), .mac_en(mac_en), .mac_load(mac_load),
    .c_we(c_we), .c_addr(c_addr)
  );

  always #5 clk = ~clk;

  int mem_a [0:63];
  int mem_b [0:63];
  int mem_c [0:63];
  int a_rd, b_rd, acc;
  int cyc = 0;
  int base = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      a_rd <= mem_a[a_addr[5:0]];
      b_rd <= mem_b[b_addr[5:0]];
    end
    if (mac_en) acc <= mac_load ? a_rd * b_rd : acc + a_rd * b_rd;
    if (c_we) mem_c[c_addr[5:0]] <= acc;
  end

  // Event monitor, sampled on the falling edge; cycle numbers are relative to start acceptance.
  logic mon_clr = 1'b0;
  int rd_cnt, mac_cnt, load_cnt, we_cnt, busy_cnt, busy_first, busy_last, done_cnt, done_cyc;
  int err_cnt, err_cyc, mac_first, addr_n;
  int a_log [0:7];
  int b_log [0:7];
  int we_cyc [0:15];
  int we_adr [0:15];

  always @(negedge clk) begin
    if (mon_clr) begin
      rd_cnt <= 0; mac_cnt <= 0; load_cnt <= 0; we_cnt <= 0; busy_cnt <= 0;
      busy_first <= -1; busy_last <= -1; done_cnt <= 0; done_cyc <= -1;
      err_cnt <= 0; err_cyc <= -1; mac_first <= -1; addr_n <= 0;
    end else begin
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (addr_n < 8) begin
          a_log[addr_n] <= int'(a_addr);
          b_log[addr_n] <= int'(b_addr);
          addr_n <= addr_n + 1;
        end
      end
      if (mac_en) begin
        mac_cnt <= mac_cnt + 1;
        if (mac_first < 0) mac_first <= cyc - base;
        if (mac_load) load_cnt <= load_cnt + 1;
      end
      if (c_we) begin
        we_cnt <= we_cnt + 1;
        if (we_cnt < 16) begin
          we_cyc[we_cnt] <= cyc - base;
          we_adr[we_cnt] <= int'(c_addr);
        end
      end
      if (busy) begin
        busy_cnt <= busy_cnt + 1;
        if (busy_first < 0) busy_first <= cyc - base;
        busy_last <= cyc - base;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc - base;
      end
      if (err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc - base;
      end
    end
  end

  task automatic start_run(input int n, input bit hold);
    @(posedge clk); #1;
    start = 1'b1;
    size = 8'(n);
    base = cyc;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int t = 0;
    while (done_cnt < target && t < limit) begin
      @(posedge clk);
      t++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL %s_timeout: done_cnt=%0d required=%0d", name, done_cnt, target);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_c();
    for (int a = 0; a < 64; a++) mem_c[a] = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; size = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, rd_en, mac_en, mac_load, c_we, a_addr, b_addr, c_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b rd=%b mac=%b we=%b required all 0",
               busy, done, err, rd_en, mac_en, c_we);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, rd_en, mac_en, c_we} !== 6'b0) begin
      bad++;
      $display("FAIL idle_outputs: busy=%b done=%b err=%b required 0", busy, done, err);
    end
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_n1();
    mem_a[1] = 3; mem_b[1] = 5; clear_c();
    start_run(1, 1'b0);
    wait_done(1, 20, "n1");
    total++;
    if (mac_first !== 2 || load_cnt !== 1 || mac_cnt !== 1) begin
      bad++;
      $display("FAIL n1_mac: first=%0d loads=%0d macs=%0d required 2/1/1", mac_first, load_cnt, mac_cnt);
    end
    total++;
    if (we_cnt !== 1 || we_cyc[0] !== 3 || we_adr[0] !== 1) begin
      bad++;
      $display("FAIL n1_write: cnt=%0d cyc=%0d addr=%0d required 1/3/1", we_cnt, we_cyc[0], we_adr[0]);
    end
    total++;
    if (mem_c[1] !== 15 || done_cyc !== 4) begin
      bad++;
      $display("FAIL n1_result: c1=%0d done_cyc=%0d required 15/4", mem_c[1], done_cyc);
    end
    $display("test_n1: C=%0d done_cyc=%0d", mem_c[1], done_cyc);
  endtask

  task automatic test_n2();
    int exp_c [4] = '{19, 22, 43, 50};
    int exp_w [4] = '{4, 6, 8, 10};
    for (int a = 0; a < 4; a++) begin
      mem_a[a + 1] = a + 1;
      mem_b[a + 1] = a + 5;
    end
    clear_c();
    start_run(2, 1'b0);
    size = 8'd9;
    wait_done(1, 40, "n2");
    for (int e = 0; e < 4; e++) begin
      total++;
      if (mem_c[e + 1] !== exp_c[e] || we_cyc[e] !== exp_w[e]) begin
        bad++;
        $display("FAIL n2_elem%0d: value=%0d cyc=%0d required %0d/%0d",
                 e, mem_c[e + 1], we_cyc[e], exp_c[e], exp_w[e]);
      end
    end
    total++;
    if (we_cnt !== 4 || done_cyc !== 11 || done_cnt !== 1) begin
      bad++;
      $display("FAIL n2_count: writes=%0d done_cyc=%0d dones=%0d required 4/11/1", we_cnt, done_cyc, done_cnt);
    end
    total++;
    if (busy_first !== 1 || busy_last !== 10 || busy_cnt !== 10) begin
      bad++;
      $display("FAIL n2_busy: first=%0d last=%0d cnt=%0d required 1/10/10", busy_first, busy_last, busy_cnt);
    end
    $display("test_n2: C=%0d %0d %0d %0d done_cyc=%0d", mem_c[1], mem_c[2], mem_c[3], mem_c[4], done_cyc);
  endtask

  task automatic test_n3_identity(input int bofs, input string name);
    int exp_a [6] = '{1, 2, 3, 1, 2, 3};
    int exp_b [6] = '{1, 4, 7, 2, 5, 8};
    for (int a = 1; a <= 9; a++) begin
      mem_a[a] = (a == 1 || a == 5 || a == 9) ? 1 : 0;
      mem_b[a] = bofs + 7 * a;
    end
    clear_c();
    start_run(3, 1'b0);
    wait_done(1, 60, name);
    for (int e = 0; e < 6; e++) begin
      total++;
      if (a_log[e] !== exp_a[e] || b_log[e] !== exp_b[e]) begin
        bad++;
        $display("FAIL %s_addr%0d: a=%0d b=%0d required %0d/%0d", name, e, a_log[e], b_log[e], exp_a[e], exp_b[e]);
      end
    end
    for (int e = 1; e <= 9; e++) begin
      total++;
      if (mem_c[e] !== bofs + 7 * e) begin
        bad++;
        $display("FAIL %s_c%0d: got=%0d required %0d", name, e, mem_c[e], bofs + 7 * e);
      end
    end
    total++;
    if (we_cnt !== 9 || done_cyc !== 30 || mac_cnt !== 27 || load_cnt !== 9) begin
      bad++;
      $display("FAIL %s_count: writes=%0d done_cyc=%0d macs=%0d loads=%0d required 9/30/27/9",
               name, we_cnt, done_cyc, mac_cnt, load_cnt);
    end
    $display("test_%s: writes=%0d done_cyc=%0d", name, we_cnt, done_cyc);
  endtask

  task automatic test_zero_and_err();
    start_run(0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== 1 || done_cyc !== 1 || rd_cnt + mac_cnt + we_cnt + busy_cnt !== 0) begin
      bad++;
      $display("FAIL zero_size: dones=%0d done_cyc=%0d rd=%0d mac=%0d we=%0d busy=%0d required 1/1/0/0/0/0",
               done_cnt, done_cyc, rd_cnt, mac_cnt, we_cnt, busy_cnt);
    end
    start_run(17, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (err_cnt !== 1 || err_cyc !== 1 || busy_cnt !== 0 || done_cnt !== 0 || rd_cnt !== 0) begin
      bad++;
      $display("FAIL oversize: errs=%0d err_cyc=%0d busy=%0d dones=%0d rd=%0d required 1/1/0/0/0",
               err_cnt, err_cyc, busy_cnt, done_cnt, rd_cnt);
    end
    $display("test_zero_and_err: zero done_cyc=1 err_cyc=%0d", err_cyc);
  endtask

  task automatic test_back_to_back();
    int t;
    for (int a = 0; a < 4; a++) begin
      mem_a[a + 1] = a + 1;
      mem_b[a + 1] = a + 5;
    end
    clear_c();
    start_run(2, 1'b1);
    t = 0;
    while (done_cnt < 1 && t < 40) begin
      @(posedge clk);
      t++;
    end
    #1;
    total++;
    if (done_cyc !== 11 || rd_cnt !== 8 || we_cnt !== 4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL held_first: done_cyc=%0d rd=%0d we=%0d busy=%b required 11/8/4/0",
               done_cyc, rd_cnt, we_cnt, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL held_restart: busy=%b required 1", busy);
    end
    wait_done(2, 40, "held_second");
    total++;
    if (we_cnt !== 8 || mem_c[1] !== 19 || mem_c[4] !== 50) begin
      bad++;
      $display("FAIL held_result: writes=%0d c1=%0d c4=%0d required 8/19/50", we_cnt, mem_c[1], mem_c[4]);
    end
    $display("test_back_to_back: dones=%0d writes=%0d", done_cnt, we_cnt);
  endtask

  task automatic test_reset_midrun();
    int we_snap, done_snap;
    start_run(3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, err, rd_en, mac_en, mac_load, c_we, a_addr, b_addr, c_addr} !== '0) begin
      bad++;
      $display("FAIL midrun_async: busy=%b rd=%b mac=%b we=%b a=%0d b=%0d required all 0",
               busy, rd_en, mac_en, c_we, a_addr, b_addr);
    end
    we_snap = we_cnt;
    done_snap = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (we_cnt !== we_snap || done_cnt !== done_snap || we_snap !== 0) begin
      bad++;
      $display("FAIL midrun_quiet: writes=%0d dones=%0d required 0/%0d", we_cnt, done_cnt, done_snap);
    end
    $display("test_reset_midrun: writes after reset=%0d", we_cnt);
    test_n3_identity(100, "after_reset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; size = 8'd0;
    a_rd = 0; b_rd = 0; acc = 0;
    for (int a = 0; a < 64; a++) begin
      mem_a[a] = 0;
      mem_b[a] = 0;
      mem_c[a] = -1;
    end
    test_reset();
    test_n1();
    test_n2();
    test_n3_identity(2, "n3");
    test_zero_and_err();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
